// File: rtl/toggle_decoder.sv
// toggle_decoder
// Receive side of a toggle link. The asynchronous toggling line in_Q is
// brought into the clk domain through a two-stage synchronizer. Each accepted
// level change produces a one-cycle out_T pulse and bumps an 8-bit event count.
// The clocks between consecutive accepted toggles are reported on out_period
// with an out_valid strobe. out_stall flags a line that has been quiet for
// TIMEOUT clocks.
//
// Optional build macro: TOGGLE_DEC_GLITCH_FILTER_EN
//   When defined, a level change on the synchronized line must persist for
//   FILT_LEN consecutive samples before it is accepted.
//   When undefined, every synchronized change is accepted. Latency is then
//   3 clocks.
module toggle_decoder #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1000,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Q,
    output logic             out_T,
    output logic             out_level,
    output logic [CNT_W-1:0] out_period,
    output logic             out_valid,
    output logic             out_stall,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALL   = 2'd2
    } state_t;

    // Last count value before a quiet line is declared stalled.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST_C = CNT_W'(TIMEOUT - 1);

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
    // A change is accepted on its FILT_LEN-th consecutive differing sample.
    localparam logic [3:0] FILT_THR_C = 4'(FILT_LEN - 1);
`else
    // Threshold zero accepts the first differing sample. FILT_LEN only keeps a
    // common parameter list for both builds.
    localparam logic [3:0] FILT_THR_C = 4'(FILT_LEN) & 4'h0;
`endif

    logic             s1_r;
    logic             s2_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       fcnt_r;
    logic [3:0]       fcnt_nxt_s;
    logic             diff_s;
    logic             accept_s;
    logic             level_nxt_s;
    logic             t_nxt_s;
    logic [CNT_W-1:0] period_nxt_s;
    logic             valid_nxt_s;
    logic             stall_nxt_s;
    logic [7:0]       count_nxt_s;

    // Two-flop synchronizer for the asynchronous toggle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= in_Q;
            s2_r <= s1_r;
        end
    end

    // Acceptance, glitch-filter counter, FSM next state and next output values.
    always_comb begin
        diff_s       = (s2_r != out_level);
        accept_s     = diff_s && (fcnt_r == FILT_THR_C);
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        fcnt_nxt_s   = 4'd0;
        level_nxt_s  = out_level;
        t_nxt_s      = 1'b0;
        period_nxt_s = out_period;
        valid_nxt_s  = 1'b0;
        stall_nxt_s  = out_stall;
        count_nxt_s  = out_count;

        if (diff_s && !accept_s) begin
            fcnt_nxt_s = fcnt_r + 4'd1;
        end else begin
            fcnt_nxt_s = 4'd0;
        end

        if (accept_s) begin
            level_nxt_s = s2_r;
            t_nxt_s     = 1'b1;
            count_nxt_s = out_count + 8'd1;
        end else begin
            level_nxt_s = out_level;
            t_nxt_s     = 1'b0;
            count_nxt_s = out_count;
        end

        case (state_r)
            ST_IDLE: begin
                // No reference edge yet, so the first toggle only starts timing.
                if (accept_s) begin
                    state_nxt_s = ST_MEASURE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // A toggle on the timeout cycle still counts as a valid period.
                if (accept_s) begin
                    period_nxt_s = cnt_r + CNT_W'(1);
                    valid_nxt_s  = 1'b1;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                end else if (cnt_r == TIMEOUT_LAST_C) begin
                    state_nxt_s = ST_STALL;
                    stall_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STALL: begin
                // Recovery toggle restarts timing and holds the old period.
                if (accept_s) begin
                    state_nxt_s = ST_MEASURE;
                    stall_nxt_s = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                stall_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Period/filter counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            fcnt_r     <= 4'd0;
            out_level  <= 1'b0;
            out_T      <= 1'b0;
            out_period <= {CNT_W{1'b0}};
            out_valid  <= 1'b0;
            out_stall  <= 1'b0;
            out_count  <= 8'd0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            fcnt_r     <= fcnt_nxt_s;
            out_level  <= level_nxt_s;
            out_T      <= t_nxt_s;
            out_period <= period_nxt_s;
            out_valid  <= valid_nxt_s;
            out_stall  <= stall_nxt_s;
            out_count  <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder with default parameters (TIMEOUT = 1000).
// Inputs are driven and outputs sampled 1 time unit after each falling clock
// edge. A monitor counts out_T/out_valid pulses and records the period range.
module tb_toggle_decoder;

    logic        clk;
    logic        reset;
    logic        in_Q;
    logic        out_T;
    logic        out_level;
    logic [15:0] out_period;
    logic        out_valid;
    logic        out_stall;
    logic [7:0]  out_count;

    int checks   = 0;
    int failures = 0;
    int t_pulses = 0;
    int v_pulses = 0;
    int p_min    = 65535;
    int p_max    = 0;
    bit stall_seen = 1'b0;

    typedef struct {
        logic        in_q;
        int          hold;
        logic        exp_t;
        logic        exp_v;
        logic [15:0] exp_p;
        logic        exp_l;
    } vec_t;

    vec_t vecs[8];

    toggle_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_Q       (in_Q),
        .out_T      (out_T),
        .out_level  (out_level),
        .out_period (out_period),
        .out_valid  (out_valid),
        .out_stall  (out_stall),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (out_T) t_pulses = t_pulses + 1;
            if (out_valid) begin
                v_pulses = v_pulses + 1;
                if (int'(out_period) < p_min) p_min = int'(out_period);
                if (int'(out_period) > p_max) p_max = int'(out_period);
            end
            if (out_stall) stall_seen = 1'b1;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_T"},      32'(out_T),      32'd0);
        check({tag, "_level"},  32'(out_level),  32'd0);
        check({tag, "_period"}, 32'(out_period), 32'd0);
        check({tag, "_valid"},  32'(out_valid),  32'd0);
        check({tag, "_stall"},  32'(out_stall),  32'd0);
        check({tag, "_count"},  32'(out_count),  32'd0);
    endtask

    initial begin
        // Each record: drive in_q, wait hold clocks, then compare.
        // Acceptance happens 3 clocks after the drive. E is the acceptance
        // edge of the preceding toggle.
        vecs[0] = '{1'b1, 3,  1'b1, 1'b1, 16'd3,  1'b1}; // accepted at E+3
        vecs[1] = '{1'b0, 1,  1'b0, 1'b0, 16'd3,  1'b1}; // in flight
        vecs[2] = '{1'b1, 2,  1'b1, 1'b1, 16'd3,  1'b0}; // E+6: 1-clock low pulse
        vecs[3] = '{1'b1, 1,  1'b1, 1'b1, 16'd1,  1'b1}; // E+7: back-to-back
        vecs[4] = '{1'b1, 5,  1'b0, 1'b0, 16'd1,  1'b1}; // quiet
        vecs[5] = '{1'b0, 3,  1'b1, 1'b1, 16'd8,  1'b0}; // E+15
        vecs[6] = '{1'b1, 10, 1'b0, 1'b0, 16'd3,  1'b1}; // E+18, checked at E+25
        vecs[7] = '{1'b0, 3,  1'b1, 1'b1, 16'd10, 1'b0}; // E+28

        reset = 1'b0;
        in_Q  = 1'b0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b1;

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
        // 2-clock glitch is rejected.
        in_Q = 1'b1;
        tick(2);
        in_Q = 1'b0;
        tick(10);
        check("glitch_pulses", 32'(t_pulses),  32'd0);
        check("glitch_level",  32'(out_level), 32'd0);
        // A stable change is accepted 5 clocks later.
        in_Q = 1'b1;
        tick(4);
        check("filt_t_early", 32'(out_T), 32'd0);
        tick(1);
        check("filt_t",       32'(out_T),     32'd1);
        check("filt_level",   32'(out_level), 32'd1);
        check("filt_count",   32'(out_count), 32'd1);
        check("filt_valid",   32'(out_valid), 32'd0);
`else
        // Idle line: nothing happens and IDLE never times out.
        tick(2000);
        check("idle_pulses", 32'(t_pulses),   32'd0);
        check("idle_stall",  32'(stall_seen), 32'd0);
        check_all_zero("idle");

        // Square wave with half-period 20: 10 toggles.
        p_min = 65535;
        p_max = 0;
        v_pulses = 0;
        in_Q = 1'b1;
        tick(2);
        check("first_t_early", 32'(out_T), 32'd0);
        tick(1);
        check("first_t",       32'(out_T),     32'd1);
        check("first_valid",   32'(out_valid), 32'd0);
        tick(17);
        for (int i = 0; i < 9; i++) begin
            in_Q = ~in_Q;
            tick(20);
        end
        check("sq_pulses", 32'(t_pulses),  32'd10);
        check("sq_count",  32'(out_count), 32'd10);
        check("sq_valids", 32'(v_pulses),  32'd9);
        check("sq_pmin",   32'(p_min),     32'd20);
        check("sq_pmax",   32'(p_max),     32'd20);
        check("sq_level",  32'(out_level), 32'd0);

        // Toggle, then hold: stall exactly 1000 clocks after acceptance.
        in_Q = 1'b1;
        tick(3);
        check("pre_stall_period", 32'(out_period), 32'd20);
        tick(999);
        check("stall_early", 32'(out_stall), 32'd0);
        tick(1);
        check("stall_set",   32'(out_stall), 32'd1);
        in_Q = 1'b0;
        tick(3);
        check("recover_stall",  32'(out_stall),  32'd0);
        check("recover_t",      32'(out_T),      32'd1);
        check("recover_valid",  32'(out_valid),  32'd0);
        check("recover_period", 32'(out_period), 32'd20);
        tick(47);
        in_Q = 1'b1;
        tick(3);
        check("p50_valid",  32'(out_valid),  32'd1);
        check("p50_period", 32'(out_period), 32'd50);

        // Toggle exactly TIMEOUT clocks later: the toggle wins.
        tick(997);
        in_Q = 1'b0;
        tick(3);
        check("p1000_valid",  32'(out_valid),  32'd1);
        check("p1000_period", 32'(out_period), 32'd1000);
        check("p1000_stall",  32'(out_stall),  32'd0);

        // Table of short periods, including back-to-back toggles.
        for (int i = 0; i < 8; i++) begin
            in_Q = vecs[i].in_q;
            tick(vecs[i].hold);
            check($sformatf("vec%0d_T", i),      32'(out_T),      32'(vecs[i].exp_t));
            check($sformatf("vec%0d_valid", i),  32'(out_valid),  32'(vecs[i].exp_v));
            check($sformatf("vec%0d_period", i), 32'(out_period), 32'(vecs[i].exp_p));
            check($sformatf("vec%0d_level", i),  32'(out_level),  32'(vecs[i].exp_l));
            check($sformatf("vec%0d_stall", i),  32'(out_stall),  32'd0);
        end
        check("tbl_count", 32'(out_count), 32'd20);

        // Bring the total to 300 toggles: the count wraps to 44.
        for (int i = 0; i < 280; i++) begin
            in_Q = ~in_Q;
            tick(2);
        end
        tick(3);
        check("wrap_pulses", 32'(t_pulses),   32'd300);
        check("wrap_count",  32'(out_count),  32'd44);
        check("wrap_period", 32'(out_period), 32'd2);

        // Asynchronous reset mid-period, released with in_Q high.
        in_Q = 1'b1;
        tick(1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(1);
        reset = 1'b1;
        tick(2);
        check("rel_t_early", 32'(out_T), 32'd0);
        tick(1);
        check("rel_t",      32'(out_T),      32'd1);
        check("rel_valid",  32'(out_valid),  32'd0);
        check("rel_level",  32'(out_level),  32'd1);
        check("rel_count",  32'(out_count),  32'd1);
        check("rel_period", 32'(out_period), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_decoder.md
# toggle_decoder

Receive-side companion to the toggle flip-flop: takes an asynchronous toggling line (the TFF `out_Q` of another clock domain or board pin), synchronizes it, recovers one `out_T` pulse per toggle, and measures the clock count between consecutive toggles. It also flags a stalled line when no toggle arrives within a timeout. It sits at the input boundary of the Assign1 design, between pin/foreign-domain toggle sources and local logic that needs toggle events or rate.

## Interface
Parameters:
- `CNT_W`, 16: width of period counter and `out_period`.
- `TIMEOUT`, 1000: clocks without a toggle before stall; legal range 2..2^CNT_W-1.
- `FILT_LEN`, 3: consecutive agreeing samples needed to accept a level change (glitch filter only); legal 2..15.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; 0 clears all state immediately.
- `in_Q` input 1: asynchronous toggling line.
- `out_T` output 1: one-cycle pulse per accepted toggle.
- `out_level` output 1: accepted (synchronized/filtered) level of `in_Q`.
- `out_period` output CNT_W: clocks between the last two accepted toggles.
- `out_valid` output 1: one-cycle pulse when `out_period` is updated.
- `out_stall` output 1: high while in STALL.
- `out_count` output 8: accepted-toggle count, modulo 256.

## Operation
- Sync: `s1 <= in_Q; s2 <= s1`; both reset to 0.
- Accept (no filter): toggle when `s2 != out_level`; then `out_level <= s2`, `out_T <= 1` for one cycle.
- Period counter `cnt` (CNT_W bits): set to 0 on every accepted toggle; else +1 per cycle in MEASURE; frozen in IDLE and STALL.
- FSM, reset state IDLE:
  - IDLE: toggle -> MEASURE, `cnt` = 0, no `out_valid` (no prior reference edge).
  - MEASURE: toggle -> `out_period <= cnt + 1`, `out_valid` pulse, `cnt` = 0, stay. No toggle and `cnt == TIMEOUT-1` -> STALL, `out_stall <= 1`.
  - STALL: toggle -> MEASURE, `out_stall <= 0`, `cnt` = 0, no `out_valid`, `out_period` held.
- Simultaneous toggle and timeout in MEASURE: toggle wins; valid with period TIMEOUT; no stall.
- `out_count` increments on every accepted toggle in all states; 255 wraps to 0.
- Reset values: `out_T`=0, `out_level`=0, `out_period`=0, `out_valid`=0, `out_stall`=0, `out_count`=0, state IDLE.
- Reset mid-operation: all outputs and state clear asynchronously; partial period discarded. If `in_Q`=1 at reset release, it is accepted as a toggle (level resets to 0) and takes IDLE -> MEASURE.

## Timing
- `in_Q` settled before edge 1: `s1` at edge 1, `s2` at edge 2, `out_T`/`out_level` at edge 3. Latency 3 clocks without filter.
- With filter: latency 2+FILT_LEN clocks (5 at default).
- `out_valid`, `out_period`, `out_stall` and `out_count` update on the same edge as `out_T`, or on the timeout edge for stall.
- Toggles accepted at edges 10 and 30 -> `out_period` = 20.
- Stall asserts TIMEOUT clocks after the last accepted toggle. Max reported period = TIMEOUT.
- Back-to-back toggles 1 clock apart (no filter) are legal -> period 1.

## Configuration
- `TOGGLE_DEC_GLITCH_FILTER_EN` defined: a 4-bit counter `fcnt` increments while `s2 != out_level` and clears when they are equal or on acceptance. A toggle is accepted on the cycle `s2 != out_level` with `fcnt == FILT_LEN-1`, i.e. the FILT_LEN-th consecutive differing sample. Pulses on `s2` shorter than FILT_LEN clocks are ignored.
- Undefined: no filter; every `s2` change is accepted, latency 3.

## Test plan
- Reset, `in_Q` = 0, run 2000 clocks -> no `out_T`. Stays IDLE, `out_stall` = 0 (IDLE never times out). All outputs 0.
- Square wave, half-period 20 clocks, 10 toggles -> 10 `out_T` pulses, `out_count` = 10. 9 `out_valid` pulses, each `out_period` = 20. Without filter, first `out_T` comes 3 clocks after the first `in_Q` change.
- Toggle, then hold 1000 clocks -> `out_stall` = 1 exactly 1000 clocks after the toggle. Next toggle -> `out_stall` = 0, no `out_valid`. Following toggle 50 clocks later -> `out_period` = 50.
- Second toggle exactly TIMEOUT = 1000 clocks after the first -> `out_valid` with `out_period` = 1000, `out_stall` stays 0.
- With `TOGGLE_DEC_GLITCH_FILTER_EN`: 2-clock high glitch -> no `out_T`, `out_level` = 0. 3-clock-stable change -> `out_T` 5 clocks after the change.
- 300 toggles -> `out_count` = 44 (wrapped). Assert `reset` = 0 mid-period -> all outputs 0 immediately. Release with `in_Q` = 1 -> one `out_T`, no `out_valid`.
